// File: rtl/cache_ctrl_if.sv
// Signal bundle between the cache read-path controller and its CPU, cache-array and memory neighbours.
// The slave modport is the controller's view; master is the surrounding environment.
interface cache_ctrl_if;
  logic         cpu_req;
  logic [15:0]  cpu_adr;
  logic         cpu_busy;
  logic         cpu_ready;
  logic [31:0]  cpu_data;

  logic [15:0]  cache_adr;
  logic         cache_hit;
  logic [31:0]  cache_rdata;
  logic         cache_write;
  logic [127:0] cache_wblock;

  logic         mem_req;
  logic [15:0]  mem_adr;
  logic         mem_valid;
  logic [31:0]  mem_rdata;

  logic [15:0]  hit_count;
  logic [15:0]  miss_count;

  modport slave (
    input  cpu_req, cpu_adr, cache_hit, cache_rdata, mem_valid, mem_rdata,
    output cpu_busy, cpu_ready, cpu_data, cache_adr, cache_write, cache_wblock,
           mem_req, mem_adr, hit_count, miss_count
  );

  modport master (
    output cpu_req, cpu_adr, cache_hit, cache_rdata, mem_valid, mem_rdata,
    input  cpu_busy, cpu_ready, cpu_data, cache_adr, cache_write, cache_wblock,
           mem_req, mem_adr, hit_count, miss_count
  );
endinterface

// File: rtl/cache_ctrl.sv
// Read-path controller for a direct-mapped 4-word-block cache: probe, fill a block from memory on a
// miss, write it back to the array, re-probe and return the word; keeps saturating hit/miss counters.
module cache_ctrl (
  input  logic          clk,
  input  logic          rst,
  cache_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPARE,
    S_FILL,
    S_WRITE,
    S_RESPOND
  } state_e;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  state_e         state_q, state_d;
  logic [15:0]    adr_q, adr_d;
  logic [127:0]   block_q, block_d;
  logic [1:0]     beat_q, beat_d;
  logic           refill_q, refill_d;
  logic [31:0]    data_q, data_d;
  logic [15:0]    hit_count_q, hit_count_d;
  logic [15:0]    miss_count_q, miss_count_d;

  // NOTE: the block buffer is a datapath register, but it is reset anyway so a fill aborted by
  // reset can never leak a stale partial block onto cache_wblock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      adr_q        <= '0;
      block_q      <= '0;
      beat_q       <= '0;
      refill_q     <= 1'b0;
      data_q       <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      // NOTE: non-blocking here so every register samples the pre-edge value of the others.
      state_q      <= state_d;
      adr_q        <= adr_d;
      block_q      <= block_d;
      beat_q       <= beat_d;
      refill_q     <= refill_d;
      data_q       <= data_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
    state_d         = state_q;
    adr_d           = adr_q;
    block_d         = block_q;
    beat_d          = beat_q;
    refill_d        = refill_q;
    data_d          = data_q;
    hit_count_d     = hit_count_q;
    miss_count_d    = miss_count_q;
    bus.cpu_ready   = 1'b0;
    bus.cache_write = 1'b0;
    bus.mem_req     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.cpu_req) begin
          adr_d    = bus.cpu_adr;
          refill_d = 1'b0;
          state_d  = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (bus.cache_hit) begin
          data_d = bus.cache_rdata;
          // The re-probe after a refill is not a first-probe hit.
          if (!refill_q && hit_count_q != CNT_MAX) hit_count_d = hit_count_q + 16'd1;
          state_d = S_RESPOND;
        end else begin
          if (miss_count_q != CNT_MAX) miss_count_d = miss_count_q + 16'd1;
          beat_d  = 2'd0;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        bus.mem_req = 1'b1;
        if (bus.mem_valid) begin
          block_d[{beat_q, 5'd0} +: 32] = bus.mem_rdata;
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        bus.cache_write = 1'b1;
        refill_d        = 1'b1;
        state_d         = S_COMPARE;
      end
      S_RESPOND: begin
        bus.cpu_ready = 1'b1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.cpu_busy     = (state_q != S_IDLE);
  assign bus.cpu_data     = data_q;
  assign bus.cache_adr    = adr_q;
  assign bus.cache_wblock = block_q;
  assign bus.mem_adr      = {adr_q[15:2], 2'b00};
  assign bus.hit_count    = hit_count_q;
  assign bus.miss_count   = miss_count_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: a behavioural cache array and memory around the DUT, and a
// transaction-level model (resident block per line, saturating counters) predicting every read.
module tb_cache_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_ctrl_if bus ();
  cache_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  // Behavioural cache array: combinational read, write at the WRITE-cycle edge.
  logic [1023:0] c_vld = '0;
  logic [2:0]    c_tag [1024];
  logic [127:0]  c_dat [1024];

  assign bus.cache_hit   = c_vld[bus.cache_adr[11:2]] && (c_tag[bus.cache_adr[11:2]] == bus.cache_adr[14:12]);
  assign bus.cache_rdata = c_dat[bus.cache_adr[11:2]][{bus.cache_adr[1:0], 5'd0} +: 32];

  int writes_seen = 0;
  always @(posedge clk) begin
    if (bus.cache_write) begin
      c_vld[bus.cache_adr[11:2]] <= 1'b1;
      c_tag[bus.cache_adr[11:2]] <= bus.cache_adr[14:12];
      c_dat[bus.cache_adr[11:2]] <= bus.cache_wblock;
      writes_seen++;
    end
  end

  // Reference model: which memory block each cache line holds, plus the two counters.
  logic [15:0] resident [int];
  logic [15:0] hit_m  = '0;
  logic [15:0] miss_m = '0;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a ^ 16'hC3A5, a + 16'h4F1B};
  endfunction

  // One CPU read from IDLE; stall: 0 back-to-back beats, 1 alternating 1,0,1,..., 2 random.
  task automatic run_read(input logic [15:0] adr, input int stall, input bit poke_req,
                          output int lat, output logic [31:0] data);
    logic [15:0]  base, src;
    logic [31:0]  exp_data;
    logic [127:0] exp_blk;
    bit           exp_hit, vld;
    int           idx, fill_cycles, fill_exp, writes, beat, exp_lat;
    idx      = int'(adr[11:2]);
    base     = {adr[15:2], 2'b00};
    exp_hit  = resident.exists(idx) && (resident[idx][14:2] == adr[14:2]);
    src      = exp_hit ? resident[idx] : base;
    exp_data = mem_word({src[15:2], adr[1:0]});
    for (int k = 0; k < 4; k++) exp_blk[32*k +: 32] = mem_word({adr[15:2], 2'(k)});

    bus.cpu_req = 1'b1;
    bus.cpu_adr = adr;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    lat = 1; fill_cycles = 0; fill_exp = 0; writes = 0; beat = 0;
    while (!bus.cpu_ready && lat < 300) begin
      bus.mem_valid = 1'b0;
      bus.mem_rdata = $urandom;
      bus.cpu_req   = 1'b0;
      if (bus.mem_req) begin
        total++;
        if (bus.mem_adr !== base) begin
          bad++;
          $display("FAIL mem_adr adr=%h got=%h want=%h", adr, bus.mem_adr, base);
        end
        case (stall)
          0:       vld = 1'b1;
          1:       vld = (fill_cycles % 2) == 0;
          default: vld = ($urandom_range(0, 1) == 1) || (fill_cycles > 20);
        endcase
        fill_cycles++;
        if (vld && beat < 4) begin
          bus.mem_valid = 1'b1;
          bus.mem_rdata = mem_word({adr[15:2], 2'(beat)});
          beat++;
          if (beat == 4) fill_exp = fill_cycles;
        end
        if (poke_req && fill_cycles == 2) begin
          bus.cpu_req = 1'b1;
          bus.cpu_adr = adr ^ 16'h0F0C;
        end
      end
      if (bus.cache_write) begin
        writes++;
        total++;
        if (bus.cache_wblock !== exp_blk) begin
          bad++;
          $display("FAIL wblock adr=%h got=%h want=%h", adr, bus.cache_wblock, exp_blk);
        end
      end
      @(negedge clk);
      lat++;
    end
    bus.mem_valid = 1'b0;
    bus.cpu_req   = 1'b0;

    if (lat >= 300) begin
      total++; bad++;
      $display("FAIL read_timeout adr=%h got=no_ready want=ready", adr);
    end else begin
      exp_lat = exp_hit ? 2 : fill_exp + 4;
      total++;
      if (lat != exp_lat) begin
        bad++;
        $display("FAIL latency adr=%h got=%0d want=%0d", adr, lat, exp_lat);
      end
      total++;
      if (bus.cpu_data !== exp_data) begin
        bad++;
        $display("FAIL cpu_data adr=%h got=%h want=%h", adr, bus.cpu_data, exp_data);
      end
      total++;
      if (bus.cpu_busy !== 1'b1) begin
        bad++;
        $display("FAIL busy_at_ready adr=%h got=%b want=1", adr, bus.cpu_busy);
      end
    end
    total++;
    if (writes != (exp_hit ? 0 : 1)) begin
      bad++;
      $display("FAIL write_pulses adr=%h got=%0d want=%0d", adr, writes, exp_hit ? 0 : 1);
    end

    if (exp_hit) begin
      if (hit_m != 16'hFFFF) hit_m++;
    end else begin
      if (miss_m != 16'hFFFF) miss_m++;
      resident[idx] = base;
    end
    total++;
    if (bus.hit_count !== hit_m) begin
      bad++;
      $display("FAIL hit_count adr=%h got=%h want=%h", adr, bus.hit_count, hit_m);
    end
    total++;
    if (bus.miss_count !== miss_m) begin
      bad++;
      $display("FAIL miss_count adr=%h got=%h want=%h", adr, bus.miss_count, miss_m);
    end

    data = bus.cpu_data;
    @(negedge clk);
    total++;
    if (bus.cpu_ready !== 1'b0 || bus.cpu_busy !== 1'b0) begin
      bad++;
      $display("FAIL back_to_idle adr=%h got=ready%b/busy%b want=0/0", adr, bus.cpu_ready, bus.cpu_busy);
    end
    total++;
    if (bus.cpu_data !== exp_data) begin
      bad++;
      $display("FAIL cpu_data_hold adr=%h got=%h want=%h", adr, bus.cpu_data, exp_data);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hit_m  = '0;
    miss_m = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.cpu_busy, bus.cpu_ready, bus.cache_write, bus.mem_req} !== 4'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=0000", {bus.cpu_busy, bus.cpu_ready, bus.cache_write, bus.mem_req});
    end
    total++;
    if (bus.cpu_data !== 32'd0 || bus.cache_wblock !== 128'd0) begin
      bad++;
      $display("FAIL reset_data got=%h/%h want=0/0", bus.cpu_data, bus.cache_wblock);
    end
    total++;
    if (bus.mem_adr !== 16'd0 || bus.cache_adr !== 16'd0) begin
      bad++;
      $display("FAIL reset_adr got=%h/%h want=0/0", bus.mem_adr, bus.cache_adr);
    end
    total++;
    if (bus.hit_count !== 16'd0 || bus.miss_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_counts got=%h/%h want=0/0", bus.hit_count, bus.miss_count);
    end
    rst = 1'b0;
    hit_m  = '0;
    miss_m = '0;
    @(negedge clk);
  endtask

  task automatic test_cold_miss_hit();
    int lat;
    logic [31:0] d;
    run_read(16'h1234, 0, 1'b0, lat, d);
    total++;
    if (lat != 8 || d !== mem_word(16'h1234)) begin
      bad++;
      $display("FAIL cold_miss got=lat%0d/%h want=lat8/%h", lat, d, mem_word(16'h1234));
    end
    total++;
    if (bus.miss_count !== 16'd1 || bus.hit_count !== 16'd0) begin
      bad++;
      $display("FAIL cold_counts got=%0d/%0d want=1/0", bus.miss_count, bus.hit_count);
    end
    run_read(16'h1236, 0, 1'b0, lat, d);
    total++;
    if (lat != 2 || d !== mem_word(16'h1236) || bus.hit_count !== 16'd1) begin
      bad++;
      $display("FAIL warm_hit got=lat%0d/%h/hits%0d want=lat2/%h/hits1", lat, d, bus.hit_count, mem_word(16'h1236));
    end
  endtask

  task automatic test_stalled_fill();
    int lat;
    logic [31:0] d;
    run_read(16'h0005, 1, 1'b0, lat, d);
    total++;
    if (lat != 11 || d !== mem_word(16'h0005)) begin
      bad++;
      $display("FAIL stalled_fill got=lat%0d/%h want=lat11/%h", lat, d, mem_word(16'h0005));
    end
  endtask

  task automatic test_conflict();
    int lat;
    logic [31:0] d;
    pulse_reset();
    @(negedge clk);
    run_read(16'h1000, 0, 1'b0, lat, d);
    run_read(16'h2000, 0, 1'b0, lat, d);
    run_read(16'h1000, 2, 1'b0, lat, d);
    total++;
    if (bus.miss_count !== 16'd3 || bus.hit_count !== 16'd0 || lat != 8 && lat < 8) begin
      bad++;
      $display("FAIL conflict got=misses%0d/hits%0d want=3/0", bus.miss_count, bus.hit_count);
    end
  endtask

  task automatic test_reset_mid_fill();
    int lat, w0;
    logic [31:0] d;
    bus.cpu_req = 1'b1;
    bus.cpu_adr = 16'h3458;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      bus.mem_valid = 1'b1;
      bus.mem_rdata = mem_word({14'h0D16, 2'(k)});
      @(negedge clk);
    end
    bus.mem_valid = 1'b0;
    total++;
    if (bus.mem_req !== 1'b1) begin
      bad++;
      $display("FAIL mid_fill_req got=%b want=1", bus.mem_req);
    end
    w0  = writes_seen;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (bus.cpu_busy !== 1'b0 || bus.mem_req !== 1'b0 || bus.cache_write !== 1'b0) begin
      bad++;
      $display("FAIL mid_fill_reset got=busy%b/req%b/wr%b want=0/0/0", bus.cpu_busy, bus.mem_req, bus.cache_write);
    end
    total++;
    if (bus.cache_wblock !== 128'd0) begin
      bad++;
      $display("FAIL mid_fill_block got=%h want=0", bus.cache_wblock);
    end
    rst = 1'b0;
    hit_m  = '0;
    miss_m = '0;
    @(negedge clk);
    total++;
    if (writes_seen != w0) begin
      bad++;
      $display("FAIL mid_fill_write got=%0d want=%0d", writes_seen, w0);
    end
    run_read(16'h3458, 0, 1'b0, lat, d);
    total++;
    if (lat != 8 || bus.miss_count !== 16'd1) begin
      bad++;
      $display("FAIL refetch got=lat%0d/misses%0d want=lat8/1", lat, bus.miss_count);
    end
  endtask

  task automatic test_ignored_inputs();
    int lat;
    logic [31:0] d;
    logic [15:0] h0, m0;
    h0 = bus.hit_count;
    m0 = bus.miss_count;
    for (int k = 0; k < 3; k++) begin
      bus.mem_valid = 1'b1;
      bus.mem_rdata = $urandom;
      @(negedge clk);
      total++;
      if (bus.cpu_busy !== 1'b0 || bus.mem_req !== 1'b0) begin
        bad++;
        $display("FAIL idle_mem_valid got=busy%b/req%b want=0/0", bus.cpu_busy, bus.mem_req);
      end
    end
    bus.mem_valid = 1'b0;
    total++;
    if (bus.hit_count !== h0 || bus.miss_count !== m0) begin
      bad++;
      $display("FAIL idle_counts got=%h/%h want=%h/%h", bus.hit_count, bus.miss_count, h0, m0);
    end
    run_read(16'h4A6B, 2, 1'b1, lat, d);
  endtask

  task automatic test_saturation();
    int lat;
    logic [31:0] d;
    run_read(16'h7770, 0, 1'b0, lat, d);
    force dut.hit_count_q = 16'hFFFD;
    #1 release dut.hit_count_q;
    hit_m = 16'hFFFD;
    @(negedge clk);
    for (int k = 0; k < 3; k++) run_read(16'h7771 + 16'(k), 0, 1'b0, lat, d);
    total++;
    if (bus.hit_count !== 16'hFFFF) begin
      bad++;
      $display("FAIL hit_saturate got=%h want=FFFF", bus.hit_count);
    end
    force dut.miss_count_q = 16'hFFFF;
    #1 release dut.miss_count_q;
    miss_m = 16'hFFFF;
    @(negedge clk);
    run_read(16'h6772, 0, 1'b0, lat, d);
    total++;
    if (bus.miss_count !== 16'hFFFF || bus.hit_count !== 16'hFFFF) begin
      bad++;
      $display("FAIL miss_saturate got=%h/%h want=FFFF/FFFF", bus.miss_count, bus.hit_count);
    end
  endtask

  task automatic test_random();
    int lat;
    logic [31:0] d;
    logic [15:0] a;
    for (int n = 0; n < 80; n++) begin
      a = {1'($urandom), 3'($urandom_range(0, 3)), 8'h5A, 2'($urandom), 2'($urandom)};
      run_read(a, $urandom_range(0, 2), 1'($urandom_range(0, 1)), lat, d);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.cpu_req   = 1'b0;
    bus.cpu_adr   = '0;
    bus.mem_valid = 1'b0;
    bus.mem_rdata = '0;
    @(negedge clk);
    test_reset();
    test_cold_miss_hit();
    test_stalled_fill();
    test_conflict();
    test_reset_mid_fill();
    test_ignored_inputs();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
